// File: rtl/emoji_pkg.sv
// Shared constants and encodings for the emoji animation engine.
package emoji_pkg;

    localparam logic [11:0] WHITE = 12'hFFF;
    localparam logic [11:0] BLACK = 12'h000;

    typedef enum logic [1:0] {
        MODE_LOOP     = 2'd0,
        MODE_PINGPONG = 2'd1,
        MODE_ONESHOT  = 2'd2,
        MODE_FREEZE   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_DONE     = 2'd2
    } seq_state_e;

endpackage

// File: rtl/emoji_anim_engine_anim_sequencer.sv
// Frame sequencer: per-frame hold timer, pending flag and index/direction FSM.
// Index only moves on a video start-of-frame pulse once the hold has expired.
module anim_sequencer
    import emoji_pkg::*;
#(
    parameter int                          NUM_FRAMES  = 4,
    parameter int                          CNT_W       = 32,
    parameter logic [NUM_FRAMES*CNT_W-1:0] HOLD_CYCLES = {32'd37_500_000, 32'd2_500_000,
                                                          32'd2_500_000, 32'd37_500_000},
    parameter int                          IDX_W       = $clog2(NUM_FRAMES)
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_frame_start,
    input  logic             i_enable,
    input  logic [1:0]       i_mode,
    output logic [IDX_W-1:0] o_frame_idx,
    output logic             o_anim_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FRAMES - 1);

    seq_state_e       r_state;
    logic [CNT_W-1:0] r_timer;
    logic [IDX_W-1:0] r_idx;
    logic             r_dir_up;
    logic             r_done;

    mode_e            w_mode;
    logic             w_run;
    logic [CNT_W-1:0] w_hold [NUM_FRAMES];
    logic [CNT_W-1:0] w_hold_last;
    logic [IDX_W-1:0] w_next_idx;
    logic             w_next_dir_up;
    logic             w_end;

    always_comb begin
        for (int unsigned i = 0; i < NUM_FRAMES; i++) begin
            w_hold[i] = HOLD_CYCLES[i*CNT_W +: CNT_W];
        end
    end

    assign w_mode      = mode_e'(i_mode);
    assign w_run       = i_enable && (w_mode != MODE_FREEZE);
    assign w_hold_last = w_hold[r_idx] - CNT_W'(1);

    // Next index is evaluated with the mode present at the advance itself.
    always_comb begin
        w_next_idx    = r_idx;
        w_next_dir_up = r_dir_up;
        w_end         = 1'b0;
        case (w_mode)
            MODE_LOOP: begin
                w_next_idx = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
            end
            MODE_PINGPONG: begin
                if (r_dir_up) begin
                    if (r_idx == LAST_IDX) begin
                        w_next_idx    = r_idx - IDX_W'(1);
                        w_next_dir_up = 1'b0;
                    end else begin
                        w_next_idx = r_idx + IDX_W'(1);
                    end
                end else begin
                    if (r_idx == '0) begin
                        w_next_idx    = IDX_W'(1);
                        w_next_dir_up = 1'b1;
                    end else begin
                        w_next_idx = r_idx - IDX_W'(1);
                    end
                end
            end
            MODE_ONESHOT: begin
                if (r_idx == LAST_IDX) begin
                    w_end = 1'b1;
                end else begin
                    w_next_idx = r_idx + IDX_W'(1);
                end
            end
            default: begin
                w_next_idx = r_idx;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_RUN;
            r_timer  <= '0;
            r_idx    <= '0;
            r_dir_up <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_run) begin
                        if (r_timer == w_hold_last) begin
                            r_state <= ST_WAIT_SOF;
                        end else begin
                            r_timer <= r_timer + CNT_W'(1);
                        end
                    end
                end
                ST_WAIT_SOF: begin
                    if (w_run && i_frame_start) begin
                        r_timer  <= '0;
                        r_idx    <= w_next_idx;
                        r_dir_up <= w_next_dir_up;
                        if (w_end) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_DONE: begin
                    // DONE behaves as a permanently pending hold until the mode leaves one-shot.
                    if (w_run && i_frame_start && (w_mode != MODE_ONESHOT)) begin
                        r_timer  <= '0;
                        r_idx    <= w_next_idx;
                        r_dir_up <= w_next_dir_up;
                        r_done   <= 1'b0;
                        r_state  <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign o_frame_idx = r_idx;
    assign o_anim_done = r_done;

endmodule

// File: rtl/emoji_anim_engine.sv
// Emoji animator: per-frame face geometry and palette lookup feeding a registered pixel colour.
// Sits between the VGA counters and the colour DAC; blanking is gated downstream.
module emoji_anim_engine
    import emoji_pkg::*;
#(
    parameter int                          H_BITS      = 10,
    parameter int                          NUM_FRAMES  = 4,
    parameter int                          CNT_W       = 32,
    parameter logic [NUM_FRAMES*CNT_W-1:0] HOLD_CYCLES = {32'd37_500_000, 32'd2_500_000,
                                                          32'd2_500_000, 32'd37_500_000},
    parameter logic [NUM_FRAMES*12-1:0]    PALETTE     = {12'hF40, 12'hF80, 12'hFD0, 12'hFF0},
    parameter int                          FACE_X0     = 324,
    parameter int                          FACE_X1     = 604,
    parameter int                          FACE_Y0     = 135,
    parameter int                          FACE_Y1     = 414,
    parameter int                          EYE_Y0      = 205,
    parameter int                          EYE_Y1      = 217,
    parameter int                          EYE_LCX     = 377,
    parameter int                          EYE_RCX     = 551,
    parameter int                          EYE_HW0     = 6,
    parameter int                          EYE_STEP    = 5,
    parameter int                          MOUTH_CX    = 464,
    parameter int                          MOUTH_Y0    = 305,
    parameter int                          MOUTH_Y1    = 310,
    parameter int                          MOUTH_VSTEP = 5,
    parameter int                          MOUTH_HW0   = 93,
    parameter int                          MOUTH_HSTEP = 10
) (
    input  logic                          clk,
    input  logic                          i_rst_n,
    input  logic [H_BITS-1:0]             i_hcounter,
    input  logic [H_BITS-1:0]             i_vcounter,
    input  logic                          i_frame_start,
    input  logic                          i_enable,
    input  logic [1:0]                    i_mode,
    output logic [11:0]                   o_color_data,
    output logic [$clog2(NUM_FRAMES)-1:0] o_frame_idx,
    output logic                          o_anim_done
);

    localparam int IDX_W = $clog2(NUM_FRAMES);
    localparam int GW    = H_BITS + 2;

    logic [IDX_W-1:0] w_frame_idx;
    logic             w_anim_done;
    logic [11:0]      w_palette [NUM_FRAMES];
    logic [GW-1:0]    w_h, w_v, w_k;
    logic [GW-1:0]    w_ehw, w_mt, w_mb, w_mhw;
    logic [GW-1:0]    w_dl, w_dr, w_dm;
    logic             w_in_face, w_eye, w_mouth;
    logic [11:0]      w_color;
    logic [11:0]      r_color;

    anim_sequencer #(
        .NUM_FRAMES  (NUM_FRAMES),
        .CNT_W       (CNT_W),
        .HOLD_CYCLES (HOLD_CYCLES),
        .IDX_W       (IDX_W)
    ) u_seq (
        .clk           (clk),
        .i_rst_n       (i_rst_n),
        .i_frame_start (i_frame_start),
        .i_enable      (i_enable),
        .i_mode        (i_mode),
        .o_frame_idx   (w_frame_idx),
        .o_anim_done   (w_anim_done)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_FRAMES; i++) begin
            w_palette[i] = PALETTE[i*12 +: 12];
        end
    end

    assign w_h = GW'(i_hcounter);
    assign w_v = GW'(i_vcounter);
    assign w_k = GW'(w_frame_idx);

    assign w_ehw = GW'(EYE_HW0)   + w_k * GW'(EYE_STEP);
    assign w_mt  = GW'(MOUTH_Y0)  - w_k * GW'(MOUTH_VSTEP);
    assign w_mb  = GW'(MOUTH_Y1)  + w_k * GW'(MOUTH_VSTEP);
    assign w_mhw = GW'(MOUTH_HW0) + w_k * GW'(MOUTH_HSTEP);

    // Absolute horizontal distances from each feature centre, kept unsigned.
    assign w_dl = (w_h >= GW'(EYE_LCX))  ? w_h - GW'(EYE_LCX)  : GW'(EYE_LCX)  - w_h;
    assign w_dr = (w_h >= GW'(EYE_RCX))  ? w_h - GW'(EYE_RCX)  : GW'(EYE_RCX)  - w_h;
    assign w_dm = (w_h >= GW'(MOUTH_CX)) ? w_h - GW'(MOUTH_CX) : GW'(MOUTH_CX) - w_h;

    assign w_in_face = (w_h >= GW'(FACE_X0)) && (w_h < GW'(FACE_X1)) &&
                       (w_v >= GW'(FACE_Y0)) && (w_v < GW'(FACE_Y1));
    assign w_eye     = (w_v >= GW'(EYE_Y0)) && (w_v < GW'(EYE_Y1)) &&
                       ((w_dl < w_ehw) || (w_dr < w_ehw));
    assign w_mouth   = (w_v >= w_mt) && (w_v < w_mb) && (w_dm < w_mhw);

    always_comb begin
        w_color = w_palette[w_frame_idx];
        if (!w_in_face) begin
            w_color = WHITE;
        end else if (w_eye || w_mouth) begin
            w_color = BLACK;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_color <= WHITE;
        end else begin
            r_color <= w_color;
        end
    end

    assign o_color_data = r_color;
    assign o_frame_idx  = w_frame_idx;
    assign o_anim_done  = w_anim_done;

endmodule

// File: tb/tb_emoji_anim_engine.sv
// Scoreboard bench for emoji_anim_engine: a frame-level reference model predicts colour, index and done.
module tb_emoji_anim_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  hc, vc;
    logic        fs, en;
    logic [1:0]  mode;
    logic [11:0] color;
    logic [1:0]  idx;
    logic        done;

    always #20 clk = ~clk;

    emoji_anim_engine #(
        .NUM_FRAMES  (4),
        .CNT_W       (32),
        .HOLD_CYCLES ({32'd4, 32'd2, 32'd2, 32'd4})
    ) dut (
        .clk           (clk),
        .i_rst_n       (rst_n),
        .i_hcounter    (hc),
        .i_vcounter    (vc),
        .i_frame_start (fs),
        .i_enable      (en),
        .i_mode        (mode),
        .o_color_data  (color),
        .o_frame_idx   (idx),
        .o_anim_done   (done)
    );

    typedef struct {
        logic [11:0] c;
        int          fidx;
        bit          fdone;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model state: frame index, ping-pong step, done flag, enabled cycles spent in this frame.
    int   m_idx, m_dir, m_elapsed;
    bit   m_done;
    int   hold_tbl [4] = '{4, 2, 2, 4};

    function automatic int iabs(int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic logic [11:0] ref_color(int h, int v, int k);
        logic [11:0] pal [4] = '{12'hFF0, 12'hFD0, 12'hF80, 12'hF40};
        int ehw = 6 + 5 * k;
        int mt  = 305 - 5 * k;
        int mb  = 310 + 5 * k;
        int mhw = 93 + 10 * k;
        if (h < 324 || h >= 604 || v < 135 || v >= 414) return 12'hFFF;
        if (v >= 205 && v < 217 && (iabs(h - 377) < ehw || iabs(h - 551) < ehw)) return 12'h000;
        if (v >= mt && v < mb && iabs(h - 464) < mhw) return 12'h000;
        return pal[k];
    endfunction

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_idx     = 0;
        m_dir     = 1;
        m_elapsed = 0;
        m_done    = 0;
    endfunction

    // One clock of the animation rules, from the state before the edge.
    function automatic void model_clock(bit f, bit e, int md);
        bit run  = e && (md != 3);
        bit pend = m_done || (m_elapsed >= hold_tbl[m_idx]);
        if (run && pend && f) begin
            if (m_done && md == 2) begin
                // a finished one-shot stays put
            end else if (!m_done && md == 2 && m_idx == 3) begin
                m_done = 1;
            end else begin
                m_done    = 0;
                m_elapsed = 0;
                if (md == 0) m_idx = (m_idx + 1) % 4;
                else if (md == 2) m_idx = m_idx + 1;
                else begin
                    if (m_idx + m_dir > 3 || m_idx + m_dir < 0) m_dir = -m_dir;
                    m_idx = m_idx + m_dir;
                end
            end
        end else if (run && !pend) begin
            m_elapsed++;
        end
    endfunction

    task automatic step(input int h, input int v);
        exp_t e;
        hc = 10'(h);
        vc = 10'(v);
        fs = (cyc % 10 == 0);
        cyc++;
        e.c = ref_color(h, v, m_idx);
        model_clock(fs, en, int'(mode));
        e.fidx  = m_idx;
        e.fdone = m_done;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic step_rand();
        int h, v;
        h = ($urandom_range(0, 1) == 1) ? int'($urandom_range(324, 603)) : int'($urandom_range(0, 639));
        v = ($urandom_range(0, 1) == 1) ? int'($urandom_range(135, 413)) : int'($urandom_range(0, 479));
        step(h, v);
    endtask

    task automatic run_rand(input int n);
        for (int i = 0; i < n; i++) step_rand();
    endtask

    // Reset asserted asynchronously between edges; outputs must clear without a clock.
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_color", int'(color), 12'hFFF);
        chk("reset_idx", int'(idx), 0);
        chk("reset_done", int'(done), 0);
        q.delete();
        fs = 1'b0;
        en = 1'b0;
        cyc = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #5;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && q.size() > 0) begin
            mon_e = q.pop_front();
            chk("color", int'(color), int'(mon_e.c));
            chk("frame_idx", int'(idx), mon_e.fidx);
            chk("anim_done", int'(done), int'(mon_e.fdone));
        end
    end

    initial begin
        #10ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        hc = '0; vc = '0; fs = 1'b0; en = 1'b0; mode = 2'd0;
        model_reset();
        #15;

        // Loop mode, including the outside-face and frame-0 palette points.
        do_reset();
        en = 1'b1; mode = 2'd0;
        step(300, 200);
        step(400, 150);
        run_rand(50);

        // Ping-pong.
        do_reset();
        en = 1'b1; mode = 2'd1;
        run_rand(90);

        // One-shot to the end, geometry at the last frame, then release via loop.
        do_reset();
        en = 1'b1; mode = 2'd2;
        run_rand(55);
        step(357, 210);
        step(356, 210);
        step(342, 290);
        step(464, 289);
        step(603, 413);
        step(604, 413);
        run_rand(10);
        mode = 2'd0;
        run_rand(30);

        // One-shot released into ping-pong.
        do_reset();
        en = 1'b1; mode = 2'd2;
        run_rand(50);
        mode = 2'd1;
        run_rand(40);

        // Enable dropped mid-hold, then freeze.
        do_reset();
        en = 1'b1; mode = 2'd0;
        run_rand(12);
        en = 1'b0;
        run_rand(20);
        en = 1'b1;
        run_rand(25);
        mode = 2'd3;
        run_rand(100);
        mode = 2'd0;
        run_rand(25);

        // Latency across the left face edge.
        for (int h = 318; h < 331; h++) step(h, 150);

        // Random mode/enable mix with a reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 14) == 0) en = ~en;
            if (i == 200) begin
                do_reset();
                en = 1'b1;
            end
            step_rand();
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
